cond_flag_unit: RTL
===================

// Module: cond_flag_unit
// PURPOSE
//  Parametrised, clocked successor to the combinational condition PLA.
//  - Computes the ALU flags N, Z, V and C and the test bit T, and holds them in a flag register.
//  - Evaluates 5-bit destination condition codes against those flags.
//  - Returns a registered taken/not-taken result over a valid/ready handshake.
//  - Sits between the ALU writeback and branch/predication control.
// PARAMETERS
//  DATA_W  16  ALU operand/result width (>=2)
//  FWD     1   1: forward same-cycle flag update to condition eval; 0: stall one cycle instead
// PORTS
//  clk          in   1       clock; all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  alu_valid    in   1       ALU op completes this cycle
//  flag_we      in   1       op updates flags (qualified by alu_valid)
//  alu_is_sum   in   1       op is add/sub (selects V/C update)
//  alu_carry    in   1       adder carry-out
//  alu_a        in   DATA_W  processed operand A
//  alu_b        in   DATA_W  processed operand B
//  alu_result   in   DATA_W  ALU result
//  v_out        out  1       combinational overflow of current op
//  cond_valid   in   1       condition request
//  cond_code    in   5       condition code
//  cond_ready   out  1       request accepted when cond_valid&cond_ready
//  out_valid    out  1       result valid
//  out_ready    in   1       consumer accepts result
//  cond_taken   out  1       condition result
//  flags_q      out  5       {T,N,Z,V,C} flag register
// BEHAVIOUR
//  - Reset: flags_q=0, out_valid=0, cond_taken=0. Async reset clears immediately, also mid-transfer; requests in flight are dropped.
//  - Combinational overflow:
//      v_out = alu_is_sum & (a_msb==b_msb) & (res_msb!=a_msb), with msb = bit DATA_W-1.
//  - Flag update on alu_valid&flag_we:
//      N = res_msb; Z = (result==0); T = alu_a[0].
//      If alu_is_sum: V = v_out, C = alu_carry. Otherwise V = 0 and C holds.
//  - cond_code[4]=0, cc = [3:0]:
//      0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V;
//      8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V);
//      E AL 1; F NV 0.
//  - cond_code[4]=1:
//      [3:1]==0 -> taken = T ^ cond_code[0].
//      Any other value is reserved -> taken 0.
//  - Hazard: a request and a flag update in the same cycle.
//      FWD=1: evaluate against the next-state flags.
//      FWD=0: cond_ready=0 that cycle; evaluate next cycle against the updated flags.
//  - Handshake:
//      cond_ready = (~out_valid | out_ready) & ~stall.
//      On accept: out_valid=1 next cycle and cond_taken loads. Latency is 1 cycle (2 with an FWD=0 stall).
//      out_valid falls after out_valid&out_ready unless a new request is accepted the same cycle (back-to-back, full throughput).
//      While out_valid&~out_ready, cond_taken is held stable.
//  - Flag updates proceed regardless of output backpressure.
// STRUCTURE
//  - Package cond_pkg:
//      cond_e enum of the 16 codes plus the TEST prefix;
//      flags_t packed struct {T,N,Z,V,C};
//      function eval_cond(flags_t, logic[4:0]).
//  - Sub-module cond_flag_calc: combinational next-flag/v_out logic.
//  - Top level holds the flag register, the hazard/forward mux and the output register.
// TESTING (DATA_W=16)
//  1. Reset:
//     reset, then EQ request -> out_valid one cycle later, taken=0, flags_q=0.
//  2. Signed overflow:
//     sum 0x7FFF+0x0001 -> 0x8000 -> v_out=1 that cycle; flags N=1,V=1,Z=0,C=0; GE taken=1, LT=0, VS=1.
//  3. Same-cycle hazard:
//     result 0x0000 with flag_we, and EQ the same cycle.
//     FWD=1 -> taken=1 next cycle.
//     FWD=0 -> cond_ready=0, taken=1 two cycles later.
//  4. Backpressure:
//     out_ready=0 for 3 cycles -> cond_ready=0, cond_taken stable.
//     Raise out_ready with a pending request -> back-to-back transfer.
//  5. Test bit:
//     alu_a=0x0003 with flag_we -> code 0x10 taken=1, 0x11 taken=0, reserved 0x12 taken=0.
//     A non-sum op keeps C, clears V.
//  6. Async reset:
//     rst pulse mid-cycle while out_valid=1 -> out_valid=0 before the next edge, flags_q=0.

Source files
------------

// File: rtl/cond_flag_unit_pkg.sv
// Shared types for the condition/flag unit: condition codes, the flag
// register layout and the condition evaluation function.
package cond_pkg;

    localparam int FLAG_W = 5;

    // Destination condition codes. cond_code[4]=1 selects the test-bit group.
    // In that group, 0x10 means "T set" and 0x11 means "T clear".
    typedef enum logic [4:0] {
        CC_EQ   = 5'h00,
        CC_NE   = 5'h01,
        CC_CS   = 5'h02,
        CC_CC   = 5'h03,
        CC_MI   = 5'h04,
        CC_PL   = 5'h05,
        CC_VS   = 5'h06,
        CC_VC   = 5'h07,
        CC_HI   = 5'h08,
        CC_LS   = 5'h09,
        CC_GE   = 5'h0A,
        CC_LT   = 5'h0B,
        CC_GT   = 5'h0C,
        CC_LE   = 5'h0D,
        CC_AL   = 5'h0E,
        CC_NV   = 5'h0F,
        CC_TEST = 5'h10
    } cond_e;

    // Flag register layout, MSB first: {T,N,Z,V,C}.
    typedef struct packed {
        logic t;
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    // Evaluate a condition code against a flag set. Reserved codes are not taken.
    function automatic logic eval_cond(flags_t f, logic [4:0] code);
        logic r;
        r = 1'b0;
        if (!code[4]) begin
            case (code)
                CC_EQ:   r = f.z;
                CC_NE:   r = ~f.z;
                CC_CS:   r = f.c;
                CC_CC:   r = ~f.c;
                CC_MI:   r = f.n;
                CC_PL:   r = ~f.n;
                CC_VS:   r = f.v;
                CC_VC:   r = ~f.v;
                CC_HI:   r = f.c & ~f.z;
                CC_LS:   r = ~f.c | f.z;
                CC_GE:   r = (f.n == f.v);
                CC_LT:   r = (f.n != f.v);
                CC_GT:   r = ~f.z & (f.n == f.v);
                CC_LE:   r = f.z | (f.n != f.v);
                CC_AL:   r = 1'b1;
                default: r = 1'b0;
            endcase
        end else if (code[3:1] == 3'b000) begin
            r = f.t ^ code[0];
        end
        return r;
    endfunction

endpackage

// File: rtl/cond_flag_calc.sv
// Combinational next-flag computation and signed overflow of the current op.
module cond_flag_calc
    import cond_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  flags_t            flagsCur,
    input  logic              update,
    input  logic              aluIsSum,
    input  logic              aluCarry,
    input  logic [DATA_W-1:0] aluA,
    input  logic [DATA_W-1:0] aluB,
    input  logic [DATA_W-1:0] aluResult,
    output flags_t            flagsNext,
    output logic              vOut
);

    localparam int MSB = DATA_W - 1;

    // Overflow: operands share a sign and the result sign differs from it.
    assign vOut = aluIsSum & (aluA[MSB] == aluB[MSB]) & (aluResult[MSB] != aluA[MSB]);

    // Next flags: hold unless updated. Non-sum ops clear V and keep C.
    always_comb begin
        flagsNext = flagsCur;
        if (update) begin
            flagsNext.t = aluA[0];
            flagsNext.n = aluResult[MSB];
            flagsNext.z = (aluResult == '0);
            if (aluIsSum) begin
                flagsNext.v = vOut;
                flagsNext.c = aluCarry;
            end else begin
                flagsNext.v = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Flag register plus registered condition evaluation behind a valid/ready
// handshake.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that edge.
// On the input side, cond_ready does not depend on out_valid going low first:
// a pending result drained this cycle frees the slot for a new request in the
// same cycle. While out_valid is high and out_ready is low, the result is held.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit FWD    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic              flag_we,
    input  logic              alu_is_sum,
    input  logic              alu_carry,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              v_out,
    input  logic              cond_valid,
    input  logic [4:0]        cond_code,
    output logic              cond_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              cond_taken,
    output logic [4:0]        flags_q
);

    flags_t flagsReg;
    flags_t flagsNext;
    flags_t evalFlags;
    logic   flagUpdate;
    logic   stall;
    logic   accept;
    logic   outValidReg;
    logic   takenReg;

    assign flagUpdate = alu_valid & flag_we;

    cond_flag_calc #(
        .DATA_W(DATA_W)
    ) u_calc (
        .flagsCur (flagsReg),
        .update   (flagUpdate),
        .aluIsSum (alu_is_sum),
        .aluCarry (alu_carry),
        .aluA     (alu_a),
        .aluB     (alu_b),
        .aluResult(alu_result),
        .flagsNext(flagsNext),
        .vOut     (v_out)
    );

    // Without forwarding, a request that collides with a flag update waits a cycle.
    assign stall      = !FWD && flagUpdate && cond_valid;
    assign cond_ready = (~outValidReg | out_ready) & ~stall;
    assign accept     = cond_valid & cond_ready;

    // With forwarding, evaluate against the flags that will be stored this edge.
    assign evalFlags  = FWD ? flagsNext : flagsReg;

    // Flag register: updates regardless of output backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flagsReg <= '0;
        end else begin
            flagsReg <= flagsNext;
        end
    end

    // Output register: load on accept, drop valid after a drain with no refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValidReg <= 1'b0;
            takenReg    <= 1'b0;
        end else if (accept) begin
            outValidReg <= 1'b1;
            takenReg    <= eval_cond(evalFlags, cond_code);
        end else if (out_ready) begin
            outValidReg <= 1'b0;
        end
    end

    assign out_valid  = outValidReg;
    assign cond_taken = takenReg;
    assign flags_q    = flagsReg;

endmodule
